seg_scan_ctrl: RTL

Parametrised multiplexed 7-segment display controller driving NDIG common-anode digits from a packed hex bus. Successor to the fixed 4-digit scanner with these additions:
- internal prescaler, with no external 1 kHz clock;
- per-digit decimal point and blanking;
- leading-zero suppression;
- PWM brightness with anti-ghosting dead time;
- frame-synchronous input latching.

It sits between the datapath and the board's AN/seg pins.

---
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl : multiplexed common-anode 7-segment scanner with prescaler,
//                 PWM brightness, dead time, leading-zero suppression.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl #(
  parameter int NDIG = 4,
  parameter int DIV  = 100000,
  parameter int BW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   blank,
  input  logic              lz_en,
  input  logic [BW-1:0]     bright,
  output logic [NDIG-1:0]   AN,
  output logic [6:0]        seg,
  output logic              dp_n,
  output logic              frame_tick
);

  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int            IW         = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     pwm_q;
  logic [4*NDIG-1:0] dig_q;
  logic [NDIG-1:0]   dp_q, blank_q;
  logic              lz_q;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dpn_q, dpn_d;
  logic              tick_q, tick_d;

  logic              slot_end, latch;
  logic [NDIG-1:0]   supp;
  logic [3:0]        sel_nib;
  logic              sel_dp, sel_blank, sel_supp, dark, lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign slot_end = (presc_q == PRESC_LAST);
  assign latch    = ce && (presc_q == '0) && (idx_q == '0);
  assign presc_d  = slot_end ? '0 : presc_q + 1'b1;
  assign idx_d    = !slot_end ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1);
  assign tick_d   = ce && slot_end && (idx_q == IDX_LAST);

  // A digit is suppressed only while every nibble from the top down to it is zero.
  always_comb begin
    logic zero_run;
    supp     = '0;
    zero_run = lz_q;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run = zero_run && (dig_q[4*i +: 4] == 4'h0);
      supp[i]  = zero_run;
    end
  end

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_supp  = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib   = dig_q[4*i +: 4];
        sel_dp    = dp_q[i];
        sel_blank = blank_q[i];
        sel_supp  = supp[i];
      end
    end
  end

  // The first cycle of each slot keeps all anodes off so the old digit cannot ghost.
  assign dark = sel_blank || (sel_supp && !sel_dp);
  assign lit  = (presc_q != '0) && (pwm_q <= bright) && !dark;

  always_comb begin
    an_d = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (lit && (idx_q == IW'(i))) an_d[i] = 1'b0;
    end
  end

  assign seg_d = (sel_blank || sel_supp) ? 7'h7F : hex7(sel_nib);
  assign dpn_d = sel_blank ? 1'b1 : !sel_dp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      dig_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dpn_q   <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      if (ce) begin
        presc_q <= presc_d;
        idx_q   <= idx_d;
        pwm_q   <= pwm_q + 1'b1;
        an_q    <= an_d;
        seg_q   <= seg_d;
        dpn_q   <= dpn_d;
        if (latch) begin
          dig_q   <= digits;
          dp_q    <= dp;
          blank_q <= blank;
          lz_q    <= lz_en;
        end
      end
    end
  end

  assign AN         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dpn_q;
  assign frame_tick = tick_q;

endmodule

`default_nettype wire
